text_vram_sched: RTL and testbench
==================================

Name: text_vram_sched

Overview:
- Scheduler for the single-port text RAM that feeds the text-mode pixel stage.
- Interleaves display fetches, which have a hard deadline, with buffered host writes, which use all remaining slots.
- Emits per-cell char/fg/bg to the pixel stage, with hs/vs/vOn delayed to match.
- Sits between the VGA timing generator and the text-mode colour stage.

Parameters:
COLS, 80, text columns; cell width 8 px
ROWS, 30, text rows; cell height 16 lines
ADDR_W, 12, text RAM address width; COLS*ROWS must be at most 2**ADDR_W

Ports:
clk  in  1  pixel clock
reset_n  in  1  reset; asynchronous, active-low
hsI  in  1  horizontal sync from timing generator
vsI  in  1  vertical sync from timing generator
vOn  in  1  active video from timing generator
hcount  in  10  pixel column of current cycle
vcount  in  10  line of current cycle
host_valid  in  1  host write request
host_ready  out  1  host request accepted when high with host_valid
host_addr  in  ADDR_W  cell index (row*COLS+col)
host_data  in  24  {bg[7:0], fg[7:0], code[7:0]}
wr_drop  out  1  one-cycle pulse: committed write had address out of range, discarded
ram_addr  out  ADDR_W  text RAM address
ram_we  out  1  text RAM write enable
ram_wdata  out  24  text RAM write data
ram_rdata  in  24  text RAM read data; 1-cycle latency
hsO  out  1  hsI delayed 2 cycles
vsO  out  1  vsI delayed 2 cycles
vOnO  out  1  vOn delayed 2 cycles
char  out  11  font ROM index {code[6:0], line-in-cell[3:0]}
fg  out  8  foreground colour
bg  out  8  background colour

Behaviour:
- Reset values (asynchronous): hsO=1, vsO=1, vOnO=0, char=0, fg=0, bg=0, ram_we=0, ram_addr=0, ram_wdata=0, wr_drop=0. Write buffer is EMPTY, so host_ready=1.
- Reset mid-operation: any buffered write is discarded and never reaches RAM; the fetch pipeline is flushed.
- Display slot: a cycle with vOn=1, hcount[2:0]=0, hcount<COLS*8 and vcount<ROWS*16.
- In a display slot, during cycle T:
  - ram_we=0 and ram_addr=(vcount>>4)*COLS+(hcount>>3).
  - Stage-1 register captures vcount[3:0] and a fetch flag.
- Cycle T+1: ram_rdata is valid. At the end of T+1 it is registered into fg=rdata[15:8], bg=rdata[23:16], char={rdata[6:0], row[3:0]}.
- Cycle T+2: char/fg/bg become visible and hold for 8 cycles, until the next fetch lands. When no fetch is in flight they hold their last value; downstream blanks with vOnO.
- Sync alignment: hsO/vsO/vOnO pass through two register stages (2-cycle latency), aligned with char/fg/bg.
- Write buffer FSM, states EMPTY and FULL:
  - host_ready = (state==EMPTY).
  - EMPTY to FULL: on host_valid && host_ready; latch host_addr/host_data.
  - FULL, non-display cycle: drive ram_we=1, ram_addr=buf_addr, ram_wdata=buf_data, then go to EMPTY.
  - FULL, display slot: stay FULL, ram_we=0.
  - If buf_addr >= COLS*ROWS: ram_we stays 0, wr_drop pulses, state goes to EMPTY.
- Host write timing:
  - Earliest commit is 1 cycle after accept; maximum throughput is 1 write per 2 cycles.
  - Worst-case wait is 1 extra cycle, since display slots are never adjacent.
- Priority: a display fetch always wins the RAM. A host write never delays or corrupts a fetch.
- ram_we is registered-free combinational from state and slot; ram_addr is muxed from the fetch or write address. Both are glitch-safe to the RAM at the clock edge.
- Write to the cell currently on screen: the new value appears from that cell's next fetch (next frame for the same row/line pass, or the next line of the same text row).

Optional Feature:
- Macro: TEXT_CURSOR_EN.
- When defined, add these ports:
  - cursor_addr in ADDR_W.
  - cursor_on in 1.
- When defined, add a 5-bit frame counter incremented on each falling edge of vsI; it resets to 0.
- When the fetched cell address == cursor_addr, cursor_on=1 and counter[4]=1, fg and bg are swapped at output.
- Blink period: 32 frames, 16 on and 16 off.
- When not defined: no cursor ports, no counter, fg/bg are never swapped.

Test Plan:
- Reset: reset_n=0 mid-frame -> hsO=vsO=1, vOnO=0, char/fg/bg=0, host_ready=1, ram_we=0. A pending write never appears on ram_we.
- Fetch timing: RAM cell 81 holds 0x12_34_41; drive vcount=21, hcount=8, vOn=1 -> ram_addr=81 at T. At T+2: char=0x415, fg=0x34, bg=0x12, held 8 cycles.
- Sync alignment: pulse hsI for 96 cycles -> hsO identical pulse delayed exactly 2 cycles; same for vsI and vOn.
- Write collision: host write accepted the cycle before a display slot -> ram_we=0 in the slot, ram_we=1 the next cycle with the correct addr/data; the fetch data is unaffected.
- Out-of-range: host_addr=2400, COLS=80, ROWS=30 -> no ram_we, wr_drop=1 for one cycle, host_ready returns to 1.
- Cursor (TEXT_CURSOR_EN): cursor_addr=0, cursor_on=1, cell 0 holds fg=0xFF, bg=0x00 -> after 16 vsync falls, cell 0 outputs fg=0x00, bg=0xFF; after 16 more, normal again.

Source files
------------

// File: rtl/text_vram_sched.sv
// Text RAM port scheduler: display fetches win their slots, a one-entry host write buffer uses the rest; TEXT_CURSOR_EN adds cursor blink.
// Latency: char/fg/bg and hsO/vsO/vOnO 2 cycles after the slot; host_ready drops while one write is buffered (<=1 slot of stall).
module text_vram_sched #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hsI,
    input  logic              vsI,
    input  logic              vOn,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [23:0]       host_data,
    output logic              wr_drop,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [23:0]       ram_wdata,
    input  logic [23:0]       ram_rdata,
    output logic              hsO,
    output logic              vsO,
    output logic              vOnO,
    output logic [10:0]       char,
    output logic [7:0]        fg,
    output logic [7:0]        bg
`ifdef TEXT_CURSOR_EN
    ,
    input  logic [ADDR_W-1:0] cursor_addr,
    input  logic              cursor_on
`endif
);

    localparam logic [9:0]      H_LIM = 10'(COLS * 8);
    localparam logic [9:0]      V_LIM = 10'(ROWS * 16);
    localparam logic [ADDR_W:0] CELLS = (ADDR_W + 1)'(COLS * ROWS);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} wstate_t;

    wstate_t           state_q;
    logic [ADDR_W-1:0] buf_addr_q;
    logic [23:0]       buf_data_q;

    logic              fetch_q;
    logic [3:0]        line_q;
    logic              swap_q;
    logic [10:0]       char_q, char_d;
    logic [7:0]        fg_q, fg_d, bg_q, bg_d;
    logic [1:0]        hs_q, vs_q, von_q;

    logic              slot;
    logic [ADDR_W-1:0] fetch_addr;
    logic              buf_in_range;
    logic              commit;
    logic              swap_d;
    logic              rdata_unused;

    assign slot       = vOn && (hcount[2:0] == 3'd0) && (hcount < H_LIM) && (vcount < V_LIM);
    assign fetch_addr = ADDR_W'(32'(vcount[9:4]) * COLS + 32'(hcount[9:3]));

    assign buf_in_range = ({1'b0, buf_addr_q} < CELLS);
    assign commit       = (state_q == FULL) && !slot;
    assign host_ready   = (state_q == EMPTY);
    assign ram_we       = commit && buf_in_range;
    assign wr_drop      = commit && !buf_in_range;
    assign ram_wdata    = buf_data_q;
    assign ram_addr     = slot ? fetch_addr : ((state_q == FULL) ? buf_addr_q : '0);
    assign rdata_unused = ram_rdata[7];

    // One-entry write buffer; a display slot simply holds it for a cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            buf_addr_q <= '0;
            buf_data_q <= '0;
        end else begin
            case (state_q)
                EMPTY: if (host_valid) begin
                    state_q    <= FULL;
                    buf_addr_q <= host_addr;
                    buf_data_q <= host_data;
                end
                FULL: if (!slot) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef TEXT_CURSOR_EN
    logic [4:0] frame_q;
    logic       vs_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_q   <= '0;
            vs_prev_q <= 1'b1;
        end else begin
            vs_prev_q <= vsI;
            if (vs_prev_q && !vsI) frame_q <= frame_q + 5'd1;
        end
    end

    assign swap_d = slot && cursor_on && (fetch_addr == cursor_addr) && frame_q[4];
`else
    assign swap_d = 1'b0;
`endif

    always_comb begin
        char_d = char_q;
        fg_d   = fg_q;
        bg_d   = bg_q;
        if (fetch_q) begin
            char_d = {ram_rdata[6:0], line_q};
            fg_d   = swap_q ? ram_rdata[23:16] : ram_rdata[15:8];
            bg_d   = swap_q ? ram_rdata[15:8]  : ram_rdata[23:16];
        end
    end

    // Stage 1 tags the in-flight read; stage 2 holds the cell until the next fetch lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_q <= 1'b0;
            line_q  <= '0;
            swap_q  <= 1'b0;
            char_q  <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
            hs_q    <= 2'b11;
            vs_q    <= 2'b11;
            von_q   <= 2'b00;
        end else begin
            fetch_q <= slot;
            line_q  <= vcount[3:0];
            swap_q  <= swap_d;
            char_q  <= char_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            hs_q    <= {hs_q[0], hsI};
            vs_q    <= {vs_q[0], vsI};
            von_q   <= {von_q[0], vOn};
        end
    end

    assign char = char_q;
    assign fg   = fg_q;
    assign bg   = bg_q;
    assign hsO  = hs_q[1];
    assign vsO  = vs_q[1];
    assign vOnO = von_q[1];

endmodule

// File: tb/tb_text_vram_sched.sv
// Bench for text_vram_sched: vector table of fetch/no-fetch cycles plus hand sequences for writes, collisions and reset.
module tb_text_vram_sched;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int AW    = 12;
    localparam int CELLS = COLS * ROWS;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          hsI, vsI, vOn;
    logic [9:0]    hcount, vcount;
    logic          host_valid, host_ready;
    logic [AW-1:0] host_addr;
    logic [23:0]   host_data;
    logic          wr_drop;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [23:0]   ram_wdata;
    logic [23:0]   ram_rdata;
    logic          hsO, vsO, vOnO;
    logic [10:0]   char;
    logic [7:0]    fg, bg;
`ifdef TEXT_CURSOR_EN
    logic [AW-1:0] cursor_addr;
    logic          cursor_on;
`endif

    always #5 clk = ~clk;

    text_vram_sched #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .hsI(hsI), .vsI(vsI), .vOn(vOn),
        .hcount(hcount), .vcount(vcount), .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_data(host_data), .wr_drop(wr_drop),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .hsO(hsO), .vsO(vsO), .vOnO(vOnO), .char(char), .fg(fg), .bg(bg)
`ifdef TEXT_CURSOR_EN
        , .cursor_addr(cursor_addr), .cursor_on(cursor_on)
`endif
    );

    // Single-port text RAM with one-cycle read latency
    logic [23:0] mem [4096];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct { int due; logic [10:0] ch; logic [7:0] f; logic [7:0] b; } fexp_t;
    typedef struct { logic [AW-1:0] a; logic [23:0] d; } wexp_t;
    fexp_t fq[$];
    wexp_t wq[$];
    fexp_t fe;
    wexp_t wx;

    logic [23:0] shadow [4096];
    logic [10:0] l_ch;
    logic [7:0]  l_f, l_b;
    logic        hh1, hh2, vh1, vh2, oh1, oh2;

    function automatic void push_fetch(input logic [AW-1:0] a, input logic [3:0] line, input logic sw);
        fexp_t e;
        logic [23:0] d;
        d    = shadow[a];
        e.due = cyc + 2;
        e.ch  = {d[6:0], line};
        e.f   = sw ? d[23:16] : d[15:8];
        e.b   = sw ? d[15:8]  : d[23:16];
        fq.push_back(e);
    endfunction

    // Scoreboard side: display outputs, sync delay and RAM writes every cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            fq.delete();
            wq.delete();
            l_ch = '0; l_f = '0; l_b = '0;
            hh1 = 1'b1; hh2 = 1'b1; vh1 = 1'b1; vh2 = 1'b1; oh1 = 1'b0; oh2 = 1'b0;
            chk("rst_ram_we", 32'(ram_we), 0);
            chk("rst_host_ready", 32'(host_ready), 1);
            chk("rst_wr_drop", 32'(wr_drop), 0);
            chk("rst_ram_addr", 32'(ram_addr), 0);
            chk("rst_ram_wdata", 32'(ram_wdata), 0);
        end else begin
            if (fq.size() != 0 && fq[0].due == cyc) begin
                fe = fq.pop_front();
                l_ch = fe.ch; l_f = fe.f; l_b = fe.b;
            end
            if (ram_we) begin
                if (wq.size() == 0) chk("wr_unexpected", 32'(ram_we), 0);
                else begin
                    wx = wq.pop_front();
                    chk("wr_addr", 32'(ram_addr), 32'(wx.a));
                    chk("wr_data", 32'(ram_wdata), 32'(wx.d));
                end
            end
        end
        chk("disp_char", 32'(char), 32'(l_ch));
        chk("disp_fg", 32'(fg), 32'(l_f));
        chk("disp_bg", 32'(bg), 32'(l_b));
        chk("hsO_delay", 32'(hsO), 32'(hh2));
        chk("vsO_delay", 32'(vsO), 32'(vh2));
        chk("vOnO_delay", 32'(vOnO), 32'(oh2));
        if (reset_n) begin
            hh2 = hh1; hh1 = hsI;
            vh2 = vh1; vh1 = vsI;
            oh2 = oh1; oh1 = vOn;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            vOn = 1'b0;
            host_valid = 1'b0;
        end
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [23:0] d);
        tick();
        vOn = 1'b0; host_valid = 1'b1; host_addr = a; host_data = d;
        @(negedge clk);
        chk("wr_ready", 32'(host_ready), 1);
        wq.push_back('{a: a, d: d});
        shadow[a] = d;
        tick();
        host_valid = 1'b0;
    endtask

    typedef struct {
        logic von; logic [9:0] h; logic [9:0] v; logic slot; logic [AW-1:0] addr; logic [23:0] data;
    } vec_t;
    vec_t vt[10];

    typedef struct { logic [AW-1:0] a; logic inr; } oor_t;
    oor_t ot[3];

    initial begin
        reset_n = 1'b0; hsI = 1'b1; vsI = 1'b1; vOn = 1'b0; hcount = '0; vcount = '0;
        host_valid = 1'b0; host_addr = '0; host_data = '0;
`ifdef TEXT_CURSOR_EN
        cursor_addr = '0; cursor_on = 1'b0;
`endif
        vt[0] = '{1'b1, 10'd8,   10'd21,  1'b1, 12'd81,   24'h123441};
        vt[1] = '{1'b1, 10'd0,   10'd0,   1'b1, 12'd0,    24'hC35AA5};
        vt[2] = '{1'b1, 10'd632, 10'd479, 1'b1, 12'd2399, 24'h0FF07E};
        vt[3] = '{1'b1, 10'd320, 10'd100, 1'b1, 12'd520,  24'hA55AC3};
        vt[4] = '{1'b1, 10'd0,   10'd16,  1'b1, 12'd80,   24'h00FF01};
        vt[5] = '{1'b1, 10'd640, 10'd0,   1'b0, 12'd0,    24'h0};
        vt[6] = '{1'b1, 10'd0,   10'd480, 1'b0, 12'd0,    24'h0};
        vt[7] = '{1'b1, 10'd9,   10'd21,  1'b0, 12'd0,    24'h0};
        vt[8] = '{1'b0, 10'd16,  10'd21,  1'b0, 12'd0,    24'h0};
        vt[9] = '{1'b1, 10'd624, 10'd15,  1'b1, 12'd78,   24'h55AA3C};
        ot[0] = '{12'd2400, 1'b0};
        ot[1] = '{12'd4095, 1'b0};
        ot[2] = '{12'd2399, 1'b1};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 10; i++)
            if (vt[i].slot) host_wr(vt[i].addr, vt[i].data);
        idle(2);

        // Fetch / no-fetch vectors, each followed by a full 8-cycle cell period
        for (int i = 0; i < 10; i++) begin
            tick();
            vOn = vt[i].von; hcount = vt[i].h; vcount = vt[i].v;
            if (vt[i].slot) push_fetch(vt[i].addr, vt[i].v[3:0], 1'b0);
            @(negedge clk);
            chk("vec_ram_we", 32'(ram_we), 0);
            if (vt[i].slot) chk("vec_ram_addr", 32'(ram_addr), 32'(vt[i].addr));
            idle(7);
        end

        // Back-to-back host requests: accept every other cycle, commit the cycle after
        for (int i = 0; i < 6; i++) begin
            tick();
            host_valid = 1'b1; host_addr = AW'(100 + i / 2); host_data = 24'(24'hA00000 + i);
            @(negedge clk);
            chk("tput_ready", 32'(host_ready), 32'(i % 2 == 0));
            chk("tput_we", 32'(ram_we), 32'(i % 2 == 1));
            if (i % 2 == 0) begin
                wq.push_back('{a: host_addr, d: host_data});
                shadow[host_addr] = host_data;
            end
        end
        idle(1);
        @(negedge clk);
        chk("tput_idle_we", 32'(ram_we), 0);

        // Write accepted just before a display slot to the cell being fetched
        tick();
        host_valid = 1'b1; host_addr = 12'd81; host_data = 24'h9C3E2B;
        @(negedge clk);
        chk("col_accept", 32'(host_ready), 1);
        wq.push_back('{a: 12'd81, d: 24'h9C3E2B});
        tick();
        host_valid = 1'b0; vOn = 1'b1; hcount = 10'd8; vcount = 10'd21;
        push_fetch(12'd81, 4'd5, 1'b0);
        @(negedge clk);
        chk("col_slot_we", 32'(ram_we), 0);
        chk("col_slot_addr", 32'(ram_addr), 81);
        chk("col_slot_ready", 32'(host_ready), 0);
        shadow[81] = 24'h9C3E2B;
        tick();
        vOn = 1'b0;
        @(negedge clk);
        chk("col_commit_we", 32'(ram_we), 1);
        chk("col_commit_addr", 32'(ram_addr), 81);
        chk("col_commit_data", 32'(ram_wdata), 32'h9C3E2B);
        idle(6);
        tick();
        vOn = 1'b1; hcount = 10'd8; vcount = 10'd22;
        push_fetch(12'd81, 4'd6, 1'b0);
        idle(8);

        // Address range boundary
        for (int i = 0; i < 3; i++) begin
            tick();
            host_valid = 1'b1; host_addr = ot[i].a; host_data = 24'(24'hDEAD00 + i);
            @(negedge clk);
            chk("oor_ready", 32'(host_ready), 1);
            if (ot[i].inr) begin
                wq.push_back('{a: host_addr, d: host_data});
                shadow[host_addr] = host_data;
            end
            tick();
            host_valid = 1'b0;
            @(negedge clk);
            chk("oor_drop", 32'(wr_drop), 32'(!ot[i].inr));
            chk("oor_we", 32'(ram_we), 32'(ot[i].inr));
            tick();
            @(negedge clk);
            chk("oor_drop_end", 32'(wr_drop), 0);
            chk("oor_ready_back", 32'(host_ready), 1);
        end

        // 96-cycle hsync pulse, then vsync/vOn pulse
        tick();
        hsI = 1'b0; hcount = 10'd1;
        @(negedge clk);
        chk("hs_edge_t0", 32'(hsO), 1);
        tick();
        @(negedge clk);
        chk("hs_edge_t1", 32'(hsO), 1);
        tick();
        @(negedge clk);
        chk("hs_edge_t2", 32'(hsO), 0);
        repeat (93) tick();
        tick();
        hsI = 1'b1;
        tick();
        vsI = 1'b0; vOn = 1'b1;
        repeat (20) tick();
        vsI = 1'b1; vOn = 1'b0;
        idle(4);

        // Reset with a fetch in flight and a write buffered
        tick();
        vOn = 1'b1; hcount = 10'd8; vcount = 10'd16;
        push_fetch(12'd81, 4'd0, 1'b0);
        tick();
        vOn = 1'b0; host_valid = 1'b1; host_addr = 12'd300; host_data = 24'h5A5A5A;
        tick();
        host_valid = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_we", 32'(ram_we), 0);
        chk("midrst_ready", 32'(host_ready), 1);
        chk("midrst_char", 32'(char), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("postrst_we", 32'(ram_we), 0);
        idle(6);

`ifdef TEXT_CURSOR_EN
        host_wr(12'd0, 24'h00FF10);
        repeat (16) begin tick(); vsI = 1'b0; tick(); vsI = 1'b1; end
        cursor_on = 1'b1; cursor_addr = 12'd0;
        tick();
        vOn = 1'b1; hcount = 10'd0; vcount = 10'd0;
        push_fetch(12'd0, 4'd0, 1'b1);
        idle(8);
        repeat (16) begin tick(); vsI = 1'b0; tick(); vsI = 1'b1; end
        tick();
        vOn = 1'b1; hcount = 10'd0; vcount = 10'd0;
        push_fetch(12'd0, 4'd0, 1'b0);
        idle(8);
`endif

        idle(3);
        @(negedge clk);
        chk("fetch_q_drained", 32'(fq.size()), 0);
        chk("write_q_drained", 32'(wq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
